alarm_sequencer: RTL

Controls the alarm buzzer in the alarm clock. It watches the current BCD time against the programmed alarm time and runs the ring/snooze/stop sequence. It produces a gated beep enable for the tone generator (`aud_en`). The time inputs come from the clock counter and the alarm-set registers; button inputs are already debounced single-cycle pulses.

---
 rtl/alarm_sequencer_if.sv | 37 +++
 rtl/alarm_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/alarm_sequencer_if.sv
// Bus between the alarm sequencer and its surroundings: time digits, buttons,
// tick in; buzzer controls and status out.
interface alarm_sequencer_if;
  logic       sec_tick;
  logic       alarm_en;
  logic [3:0] hourdec_bud;
  logic [3:0] hourone_bud;
  logic [3:0] mindec_bud;
  logic [3:0] minone_bud;
  logic [3:0] hourdec_now;
  logic [3:0] hourone_now;
  logic [3:0] mindec_now;
  logic [3:0] minone_now;
  logic       snooze_btn;
  logic       stop_btn;
  logic       aud_en;
  logic       ringing;
  logic       snoozing;
  logic [2:0] snooze_used;
  logic       missed;

  modport master (
    output sec_tick, alarm_en,
    output hourdec_bud, hourone_bud, mindec_bud, minone_bud,
    output hourdec_now, hourone_now, mindec_now, minone_now,
    output snooze_btn, stop_btn,
    input  aud_en, ringing, snoozing, snooze_used, missed
  );

  modport slave (
    input  sec_tick, alarm_en,
    input  hourdec_bud, hourone_bud, mindec_bud, minone_bud,
    input  hourdec_now, hourone_now, mindec_now, minone_now,
    input  snooze_btn, stop_btn,
    output aud_en, ringing, snoozing, snooze_used, missed
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm buzzer sequencer: rings on a rising edge of the time/alarm match,
// handles snooze and stop, and gates the beep enable at a 1 s on/off cadence.
module alarm_sequencer #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic               clk,
  input  logic               rst,
  alarm_sequencer_if.slave   bus
);
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned USED_W = 3;

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    ring_cnt_q, ring_cnt_d;
  logic [CNT_W-1:0]    snz_cnt_q, snz_cnt_d;
  logic [USED_W-1:0]   used_q, used_d;
  logic                phase_q, phase_d;
  logic                missed_q, missed_d;
  logic                match_q;
  logic                aud_q, ringing_q, snoozing_q;
  logic                match_c, trigger_c;

  assign match_c = ({bus.hourdec_now, bus.hourone_now, bus.mindec_now, bus.minone_now} ==
                    {bus.hourdec_bud, bus.hourone_bud, bus.mindec_bud, bus.minone_bud});
  assign trigger_c = match_c & ~match_q & bus.alarm_en & (state_q == IDLE);

  // Next-state logic; every exit to IDLE clears the per-event bookkeeping.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    used_d     = used_q;
    phase_d    = phase_q;
    missed_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ring_cnt_d = '0;
        snz_cnt_d  = '0;
        used_d     = '0;
        phase_d    = 1'b0;
        if (trigger_c) state_d = RING;
      end
      RING: begin
        if (bus.stop_btn || !bus.alarm_en) begin
          state_d = IDLE;
          used_d  = '0;
          phase_d = 1'b0;
        end else if (bus.snooze_btn && (used_q < USED_W'(MAX_SNOOZE))) begin
          state_d   = SNOOZE;
          used_d    = used_q + USED_W'(1);
          snz_cnt_d = '0;
        end else if (bus.sec_tick) begin
          if (ring_cnt_q == CNT_W'(RING_SEC - 1)) begin
            state_d  = IDLE;
            missed_d = 1'b1;
            used_d   = '0;
            phase_d  = 1'b0;
          end else begin
            ring_cnt_d = ring_cnt_q + CNT_W'(1);
            phase_d    = ~phase_q;
          end
        end
      end
      SNOOZE: begin
        if (bus.stop_btn || !bus.alarm_en) begin
          state_d = IDLE;
          used_d  = '0;
          phase_d = 1'b0;
        end else if (bus.sec_tick) begin
          if (snz_cnt_q == CNT_W'(SNOOZE_SEC - 1)) begin
            state_d    = RING;
            ring_cnt_d = '0;
            phase_d    = 1'b0;
          end else begin
            snz_cnt_d = snz_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // match_q resets high so a match already present at reset release cannot ring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      used_q     <= '0;
      phase_q    <= 1'b0;
      missed_q   <= 1'b0;
      match_q    <= 1'b1;
      aud_q      <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      used_q     <= used_d;
      phase_q    <= phase_d;
      missed_q   <= missed_d;
      match_q    <= match_c;
      aud_q      <= (state_d == RING) & ~phase_d;
      ringing_q  <= (state_d == RING);
      snoozing_q <= (state_d == SNOOZE);
    end
  end

  assign bus.aud_en      = aud_q;
  assign bus.ringing     = ringing_q;
  assign bus.snoozing    = snoozing_q;
  assign bus.snooze_used = used_q;
  assign bus.missed      = missed_q;
endmodule
